// File: rtl/wide_add_pkg.sv
// Shared definitions for the chunked wide adder: FSM encoding and index sizing.
package wide_add_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE = ST_IDLE,
      S_RUN  = ST_RUN,
      S_DONE = ST_DONE
   } state_t;

   // Chunk index width; a single chunk still needs a 1-bit index register.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/wide_add_sequencer_if.sv
// Operand/result handshake bundle between producer, sequencer and consumer.
interface wide_add_sequencer_if #(
   parameter int p_WIDTH  = 8,
   parameter int p_CHUNKS = 4
);
   localparam int N = p_WIDTH * p_CHUNKS;

   logic         iw_valid;
   logic         ow_ready;
   logic [N-1:0] iwv_x;
   logic [N-1:0] iwv_y;
   logic         iw_sub;
   logic         iw_carry;
   logic         ow_valid;
   logic         iw_ready;
   logic [N-1:0] owv_sum;
   logic         ow_carry;

   // Producer/consumer side.
   modport master (
      output iw_valid, iwv_x, iwv_y, iw_sub, iw_carry, iw_ready,
      input  ow_ready, ow_valid, owv_sum, ow_carry
   );

   // Sequencer side.
   modport slave (
      input  iw_valid, iwv_x, iwv_y, iw_sub, iw_carry, iw_ready,
      output ow_ready, ow_valid, owv_sum, ow_carry
   );
endinterface

// File: rtl/wide_add_sequencer_cla.sv
// Narrow carry-lookahead adder shared by the wide add sequencer.
module AddrCarryLookAhead #(
   parameter int p_WIDTH = 8
) (
   input  logic [p_WIDTH-1:0]   iw_a,
   input  logic [p_WIDTH-1:0]   iw_b,
   input  logic                 iw_carry,
   output logic [p_WIDTH:0]     ow_sum,
   output logic [p_WIDTH:0]     ow_dbg_carry,
   output logic [p_WIDTH-1:0]   ow_dbg_sum,
   output logic [2*p_WIDTH-1:0] ow_dbg_cs
);

   logic [p_WIDTH-1:0] gen;
   logic [p_WIDTH-1:0] prop;
   logic [p_WIDTH:0]   c;

   assign gen  = iw_a & iw_b;
   assign prop = iw_a ^ iw_b;

   // Each carry is built independently from generate/propagate and carry-in,
   // so synthesis flattens it into a lookahead tree rather than a ripple chain.
   always_comb begin : carry_calc
      logic acc;
      acc = 1'b0;
      c   = '0;
      for (int i = 0; i <= p_WIDTH; i++) begin
         acc = iw_carry;
         for (int j = 0; j < i; j++) begin
            acc = gen[j] | (prop[j] & acc);
         end
         c[i] = acc;
      end
   end

   assign ow_sum       = {c[p_WIDTH], prop ^ c[p_WIDTH-1:0]};
   assign ow_dbg_carry = c;
   assign ow_dbg_sum   = prop ^ c[p_WIDTH-1:0];
   assign ow_dbg_cs    = {gen, prop};

endmodule

// File: rtl/wide_add_sequencer.sv
// Wide add/subtract built from one narrow CLA stepped over p_CHUNKS slices,
// least significant first, with the inter-chunk carry held in a register.
module wide_add_sequencer
   import wide_add_pkg::*;
#(
   parameter int p_WIDTH  = 8,
   parameter int p_CHUNKS = 4
) (
   input  logic              iw_clk,
   input  logic              iw_rst_n,
   wide_add_sequencer_if.slave bus
);

   localparam int            N      = p_WIDTH * p_CHUNKS;
   localparam int            KW     = idx_width(p_CHUNKS);
   localparam logic [KW-1:0] K_LAST = KW'(p_CHUNKS - 1);

   state_t             state_q, state_d;
   logic [KW-1:0]      k_q;
   logic [N-1:0]       x_q, y_q, sum_q;
   logic               carry_q;
   logic [p_WIDTH-1:0] x_chunk, y_chunk;
   logic [p_WIDTH:0]   cla_sum;

   assign x_chunk = x_q[int'(k_q)*p_WIDTH +: p_WIDTH];
   assign y_chunk = y_q[int'(k_q)*p_WIDTH +: p_WIDTH];

   AddrCarryLookAhead #(.p_WIDTH(p_WIDTH)) u_cla (
      .iw_a         (x_chunk),
      .iw_b         (y_chunk),
      .iw_carry     (carry_q),
      .ow_sum       (cla_sum),
      .ow_dbg_carry (),
      .ow_dbg_sum   (),
      .ow_dbg_cs    ()
   );

   // Next-state: accept in IDLE, step chunks in RUN, hold result until taken.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (bus.iw_valid)  state_d = S_RUN;
         S_RUN:   if (k_q == K_LAST) state_d = S_DONE;
         S_DONE:  if (bus.iw_ready)  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // State register; reset aborts any operation in flight.
   always_ff @(posedge iw_clk) begin
      if (!iw_rst_n) state_q <= S_IDLE;
      else           state_q <= state_d;
   end

   // Operand capture, per-chunk result/carry update and chunk index.
   // Subtract is X + ~Y + 1, so Y is inverted once at capture time.
   always_ff @(posedge iw_clk) begin
      if (!iw_rst_n) begin
         k_q     <= '0;
         x_q     <= '0;
         y_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: if (bus.iw_valid) begin
               x_q     <= bus.iwv_x;
               y_q     <= bus.iw_sub ? ~bus.iwv_y : bus.iwv_y;
               carry_q <= bus.iw_sub | bus.iw_carry;
               k_q     <= '0;
            end
            S_RUN: begin
               sum_q[int'(k_q)*p_WIDTH +: p_WIDTH] <= cla_sum[p_WIDTH-1:0];
               carry_q                              <= cla_sum[p_WIDTH];
               if (k_q != K_LAST) k_q <= k_q + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.ow_ready = (state_q == S_IDLE);
   assign bus.ow_valid = (state_q == S_DONE);
   assign bus.owv_sum  = sum_q;
   assign bus.ow_carry = carry_q;

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Bench for wide_add_sequencer: directed table, handshake corner cases,
// random ops and sweeps of small configurations against an arithmetic model.
module tb_wide_add_sequencer;

   localparam int P_W = 4;
   localparam int P_C = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   wide_add_sequencer_if #(.p_WIDTH(P_W), .p_CHUNKS(P_C)) if0 ();
   wide_add_sequencer_if #(.p_WIDTH(2),   .p_CHUNKS(1))   if1 ();
   wide_add_sequencer_if #(.p_WIDTH(2),   .p_CHUNKS(3))   if2 ();

   wide_add_sequencer #(.p_WIDTH(P_W), .p_CHUNKS(P_C)) dut (
      .iw_clk(clk), .iw_rst_n(rst_n), .bus(if0));
   wide_add_sequencer #(.p_WIDTH(2), .p_CHUNKS(1)) dut_c1 (
      .iw_clk(clk), .iw_rst_n(rst_n), .bus(if1));
   wide_add_sequencer #(.p_WIDTH(2), .p_CHUNKS(3)) dut_c3 (
      .iw_clk(clk), .iw_rst_n(rst_n), .bus(if2));

   // One shared driver, steered to the instance selected by sel.
   logic [1:0] sel;
   logic       d_valid, d_sub, d_carry, d_ready;
   logic [7:0] d_x, d_y;
   logic       m_ready, m_valid, m_carry;
   logic [7:0] m_sum;

   assign if0.iw_valid = d_valid & (sel == 2'd0);
   assign if0.iw_ready = d_ready & (sel == 2'd0);
   assign if0.iwv_x    = d_x;
   assign if0.iwv_y    = d_y;
   assign if0.iw_sub   = d_sub;
   assign if0.iw_carry = d_carry;
   assign if1.iw_valid = d_valid & (sel == 2'd1);
   assign if1.iw_ready = d_ready & (sel == 2'd1);
   assign if1.iwv_x    = d_x[1:0];
   assign if1.iwv_y    = d_y[1:0];
   assign if1.iw_sub   = d_sub;
   assign if1.iw_carry = d_carry;
   assign if2.iw_valid = d_valid & (sel == 2'd2);
   assign if2.iw_ready = d_ready & (sel == 2'd2);
   assign if2.iwv_x    = d_x[5:0];
   assign if2.iwv_y    = d_y[5:0];
   assign if2.iw_sub   = d_sub;
   assign if2.iw_carry = d_carry;

   always_comb begin
      m_ready = if0.ow_ready;
      m_valid = if0.ow_valid;
      m_carry = if0.ow_carry;
      m_sum   = if0.owv_sum;
      case (sel)
         2'd1: begin
            m_ready = if1.ow_ready; m_valid = if1.ow_valid;
            m_carry = if1.ow_carry; m_sum = {6'd0, if1.owv_sum};
         end
         2'd2: begin
            m_ready = if2.ow_ready; m_valid = if2.ow_valid;
            m_carry = if2.ow_carry; m_sum = {2'd0, if2.owv_sum};
         end
         default: ;
      endcase
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: n-bit add with carry-in, or X + ~Y + 1 for subtract.
   // Returns {carry_out, sum}.
   function automatic logic [8:0] ref_op(input int n, input logic [7:0] x, input logic [7:0] y,
                                         input logic sub, input logic c);
      logic [15:0] mask, yy, r;
      mask = (16'd1 << n) - 16'd1;
      yy   = sub ? (~{8'd0, y} & mask) : {8'd0, y};
      r    = {8'd0, x} + yy + (sub ? 16'd1 : {15'd0, c});
      return {r[n], r[7:0] & mask[7:0]};
   endfunction

   // All drive/sample points sit 1 time unit after a rising edge.
   task automatic issue(input logic [7:0] x, input logic [7:0] y, input logic sub, input logic c);
      int t;
      t = 0;
      d_x = x; d_y = y; d_sub = sub; d_carry = c; d_valid = 1'b1;
      while (!m_ready && t < 50) begin
         @(posedge clk); #1; t++;
      end
      chk("issue_ready", 32'(m_ready), 32'(1));
      @(posedge clk); #1;
      // Scramble inputs after the accept edge; captured operands must not follow.
      d_valid = 1'b0;
      d_x = 8'($urandom); d_y = 8'($urandom);
      d_sub = 1'($urandom); d_carry = 1'($urandom);
   endtask

   task automatic wait_valid(output int lat);
      lat = 0;
      do begin
         @(posedge clk); #1; lat++;
      end while (!m_valid && lat < 50);
      if (!m_valid) chk("valid_timeout", 32'(m_valid), 32'(1));
   endtask

   task automatic release_result(input int stall);
      logic [9:0] snap;
      snap = {m_valid, m_carry, m_sum};
      repeat (stall) begin
         @(posedge clk); #1;
         chk("hold_stable", 32'({m_valid, m_carry, m_sum}), 32'(snap));
      end
      d_ready = 1'b1;
      @(posedge clk); #1;
      d_ready = 1'b0;
      chk("post_idle", 32'({m_ready, m_valid}), 32'(2'b10));
   endtask

   task automatic run_op(input logic [7:0] x, input logic [7:0] y, input logic sub, input logic c,
                         input int stall, output logic [7:0] sum, output logic carry, output int lat);
      issue(x, y, sub, c);
      wait_valid(lat);
      sum   = m_sum;
      carry = m_carry;
      release_result(stall);
   endtask

   typedef struct {
      logic [7:0] x;
      logic [7:0] y;
      logic       sub;
      logic       c;
      logic [7:0] sum;
      logic       carry;
   } vec_t;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t       vt[7];
      logic [7:0] s;
      logic       co;
      logic [8:0] r;
      int         lat;
      logic [9:0] snap;
      logic [7:0] rx, ry;
      logic       rs, rc;

      vt[0] = '{8'h3C, 8'h15, 1'b0, 1'b0, 8'h51, 1'b0};
      vt[1] = '{8'hFF, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1};
      vt[2] = '{8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0};
      vt[3] = '{8'h50, 8'h51, 1'b1, 1'b0, 8'hFF, 1'b0};
      vt[4] = '{8'h51, 8'h50, 1'b1, 1'b1, 8'h01, 1'b1};
      vt[5] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1};
      vt[6] = '{8'h22, 8'h33, 1'b0, 1'b0, 8'h55, 1'b0};

      sel = 2'd0; d_valid = 1'b0; d_ready = 1'b0;
      d_x = 8'd0; d_y = 8'd0; d_sub = 1'b0; d_carry = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      chk("reset_state", 32'({m_ready, m_valid, m_carry, m_sum}), 32'({1'b1, 1'b0, 1'b0, 8'h00}));

      // Directed vectors
      for (int i = 0; i < 7; i++) begin
         run_op(vt[i].x, vt[i].y, vt[i].sub, vt[i].c, 0, s, co, lat);
         chk("vec_sum", 32'(s), 32'(vt[i].sum));
         chk("vec_carry", 32'(co), 32'(vt[i].carry));
         chk("vec_latency", 32'(lat), 32'(P_C));
      end

      // Backpressure with ignored operand requests while DONE
      issue(8'h12, 8'h34, 1'b0, 1'b0);
      wait_valid(lat);
      chk("bp_latency", 32'(lat), 32'(P_C));
      chk("bp_result", 32'({m_carry, m_sum}), 32'({1'b0, 8'h46}));
      snap = {m_valid, m_carry, m_sum};
      repeat (5) begin
         d_valid = 1'b1; d_x = 8'hAA; d_y = 8'h11; d_sub = 1'b0; d_carry = 1'b0;
         @(posedge clk); #1;
         chk("bp_hold", 32'({m_valid, m_carry, m_sum}), 32'(snap));
         chk("bp_not_ready", 32'(m_ready), 32'(0));
      end
      d_valid = 1'b0;
      d_ready = 1'b1;
      @(posedge clk); #1;
      d_ready = 1'b0;
      chk("bp_release", 32'({m_ready, m_valid}), 32'(2'b10));
      run_op(8'hAA, 8'h11, 1'b0, 1'b0, 0, s, co, lat);
      chk("bp_next_op", 32'({co, s}), 32'({1'b0, 8'hBB}));

      // Reset after the first chunk of an operation
      issue(8'h37, 8'h21, 1'b0, 1'b0);
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk("rst_mid", 32'({m_ready, m_valid, m_carry, m_sum}), 32'({1'b1, 1'b0, 1'b0, 8'h00}));
      repeat (3) @(posedge clk);
      #1 chk("rst_no_result", 32'(m_valid), 32'(0));
      run_op(8'h22, 8'h33, 1'b0, 1'b0, 0, s, co, lat);
      chk("rst_next_op", 32'({co, s}), 32'({1'b0, 8'h55}));

      // Random ops with occasional consumer stalls
      repeat (200) begin
         rx = 8'($urandom); ry = 8'($urandom);
         rs = 1'($urandom); rc = 1'($urandom);
         run_op(rx, ry, rs, rc, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0,
                s, co, lat);
         r = ref_op(8, rx, ry, rs, rc);
         chk("rand_result", 32'({co, s}), 32'(r));
         chk("rand_latency", 32'(lat), 32'(P_C));
      end

      // Single-chunk configuration, exhaustive
      sel = 2'd1;
      for (int x = 0; x < 4; x++)
         for (int y = 0; y < 4; y++)
            for (int m = 0; m < 4; m++) begin
               run_op(8'(x), 8'(y), 1'(m >> 1), 1'(m), int'($urandom_range(0, 2)), s, co, lat);
               r = ref_op(2, 8'(x), 8'(y), 1'(m >> 1), 1'(m));
               chk("c1_result", 32'({co, s}), 32'(r));
               chk("c1_latency", 32'(lat), 32'(1));
            end

      // Three-chunk configuration, all operand pairs, op mode cycling
      sel = 2'd2;
      for (int x = 0; x < 64; x++)
         for (int y = 0; y < 64; y++) begin
            rs = 1'((x + y) >> 1);
            rc = 1'(x + y);
            run_op(8'(x), 8'(y), rs, rc, ($urandom_range(0, 3) == 0) ? 1 : 0, s, co, lat);
            r = ref_op(6, 8'(x), 8'(y), rs, rc);
            chk("c3_result", 32'({co, s}), 32'(r));
            chk("c3_latency", 32'(lat), 32'(3));
         end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
